// File: rtl/aes_encrypt_seq_pkg.sv
// Shared AES constants and byte-level helpers used by the encrypt and decrypt paths.
// Holds the S-box and Rcon tables plus the sequencer FSM encoding.
package aes_encrypt_seq_pkg;

   localparam int unsigned NumStates = 3;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } aes_fsm_e;

   // Entry 0 sits in the most significant byte.
   localparam logic [2047:0] SboxTbl = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [87:0] RconTbl = 88'h8d_01_02_04_08_10_20_40_80_1b_36;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SboxTbl[8*(255-b) +: 8];
   endfunction

   function automatic logic [7:0] rcon(input int unsigned idx);
      return RconTbl[8*(10-idx) +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_encrypt_seq_round.sv
// One AES encryption round; final_i drops MixColumns for the last round.
module aes_enc_round
   import aes_encrypt_seq_pkg::*;
(
   input  logic [127:0] state_i,
   input  logic [127:0] round_key_i,
   input  logic         final_i,
   output logic [127:0] state_o
);

   // Byte k = 4*column + row, byte 0 in the top bits.
   logic [7:0] sr [16];
   logic [7:0] mc [16];

   always_comb begin
      for (int k = 0; k < 16; k++) begin
         sr[k] = '0;
         mc[k] = '0;
      end
      state_o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[4*c+r] = sbox(state_i[127-8*(4*((c+r)%4)+r) -: 8]);
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
         mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
      end
      for (int k = 0; k < 16; k++) begin
         state_o[127-8*k -: 8] = (final_i ? sr[k] : mc[k]) ^ round_key_i[127-8*k -: 8];
      end
   end

endmodule

// File: rtl/keyExpansion.sv
// Combinational AES key schedule; round key r occupies key_sched_o[128*r +: 128].
module keyExpansion
   import aes_encrypt_seq_pkg::*;
#(
   parameter int unsigned Nk = 4,
   parameter int unsigned Nr = 10
) (
   input  logic [32*Nk-1:0]      key_i,
   output logic [128*(Nr+1)-1:0] key_sched_o
);

   localparam int unsigned NumWords = 4 * (Nr + 1);

   // One block per schedule word keeps each word a distinct net.
   for (genvar i = 0; i < NumWords; i++) begin : g_w
      logic [31:0] word;
      if (i < Nk) begin : g_key
         assign word = key_i[32*(Nk-i)-1 -: 32];
      end else begin : g_exp
         logic [31:0] prev;
         logic [31:0] temp;
         assign prev = g_w[i-1].word;
         if (i % Nk == 0) begin : g_rot
            assign temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon(i / Nk), 24'h000000};
         end else if (Nk > 6 && i % Nk == 4) begin : g_sub
            assign temp = sub_word(prev);
         end else begin : g_pass
            assign temp = prev;
         end
         assign word = g_w[i-Nk].word ^ temp;
      end
      assign key_sched_o[128*(i/4) + 32*(3-(i%4)) +: 32] = word;
   end

endmodule

// File: rtl/aes_encrypt_seq.sv
// Iterative AES encryptor: one round per clock, IDLE/RUN/DONE handshake sequencer.
module aes_encrypt_seq
   import aes_encrypt_seq_pkg::*;
#(
   parameter int unsigned N  = 128,
   parameter int unsigned Nr = 10,
   parameter int unsigned Nk = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [127:0]   in,
   input  logic [N-1:0]   key,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [127:0]   out
);

   localparam int unsigned CntW = $clog2(Nr + 1);

   aes_fsm_e                st_q, st_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [127:0]            state_q, state_d;
   logic [N-1:0]            key_q, key_d;
   logic [128*(Nr+1)-1:0]   key_sched;
   logic [127:0]            round_key;
   logic [127:0]            round_out;
   logic                    last_round;

   keyExpansion #(
      .Nk (Nk),
      .Nr (Nr)
   ) u_key_exp (
      .key_i       (key_q),
      .key_sched_o (key_sched)
   );

   assign round_key  = key_sched[128*cnt_q +: 128];
   assign last_round = (cnt_q == CntW'(Nr));

   aes_enc_round u_round (
      .state_i     (state_q),
      .round_key_i (round_key),
      .final_i     (last_round),
      .state_o     (round_out)
   );

   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      key_d   = key_q;
      unique case (st_q)
         StIdle: begin
            if (in_valid) begin
               // Round key 0 is the leading 128 key bits, taken before key_q loads.
               key_d   = key;
               state_d = in ^ key[N-1 -: 128];
               cnt_d   = CntW'(1);
               st_d    = StRun;
            end
         end
         StRun: begin
            state_d = round_out;
            if (last_round) begin
               st_d = StDone;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               st_d  = StIdle;
               cnt_d = '0;
            end
         end
         default: st_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= StIdle;
         cnt_q   <= '0;
         state_q <= '0;
         key_q   <= '0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         key_q   <= key_d;
      end
   end

   assign in_ready  = (st_q == StIdle);
   assign out_valid = (st_q == StDone);
   assign out       = state_q;

endmodule
